// File: rtl/usbdev_in_buf_ctrl.sv
// ----------------------------------------------------------------------------
// usbdev_in_buf_ctrl
//
// Packet-buffer sequencer behind the full-speed non-buffered IN protocol
// engine. Holds per-endpoint configuration (ready, buffer id, packet size).
// It snapshots that configuration when an IN transaction starts and fetches
// 32-bit words from packet SRAM. It serves bytes at the engine's get address,
// retires packets on a good termination and leaves them pending on rollback.
//
// Optional feature macro: USBDEV_IN_PREFETCH_EN
//   defined   - second word register, next word fetched ahead of use
//   undefined - single word register, on-demand fetch only
//
// Ports:
//   clk_48mhz_i, rst_ni         clock, asynchronous active-low reset
//   link_reset_i                USB bus reset
//   cfg_*                       software config write port, cfg_err_o pulse
//   ep_rdy_o / ep_sent_o        per-endpoint ready level / sent pulse
//   in_xact_* / in_ep_*         IN protocol engine interface
//   mem_*                       packet SRAM read port (req/gnt/rvalid)
// ----------------------------------------------------------------------------
module usbdev_in_buf_ctrl #(
   parameter  int unsigned NumInEps         = 12,
   parameter  int unsigned MaxInPktSizeByte = 64,
   parameter  int unsigned BufIdW           = 5,
   localparam int unsigned PktW             = $clog2(MaxInPktSizeByte),
   localparam int unsigned MemAddrW         = BufIdW + PktW - 2
) (
   input  logic                clk_48mhz_i,
   input  logic                rst_ni,
   input  logic                link_reset_i,

   input  logic                cfg_we_i,
   input  logic [3:0]          cfg_ep_i,
   input  logic [BufIdW-1:0]   cfg_buf_i,
   input  logic [PktW:0]       cfg_size_i,
   input  logic                cfg_rdy_i,
   output logic                cfg_err_o,

   output logic [NumInEps-1:0] ep_rdy_o,
   output logic [NumInEps-1:0] ep_sent_o,

   input  logic                in_xact_starting_i,
   input  logic [3:0]          in_xact_start_ep_i,
   input  logic [PktW-1:0]     in_ep_get_addr_i,
   input  logic                in_ep_data_get_i,
   input  logic                in_ep_xact_end_i,
   input  logic                in_ep_rollback_i,
   output logic [NumInEps-1:0] in_ep_has_data_o,
   output logic [NumInEps-1:0] in_ep_data_done_o,
   output logic [7:0]          in_ep_data_o,

   output logic                mem_req_o,
   output logic [MemAddrW-1:0] mem_addr_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [31:0]         mem_rdata_i
);

   localparam int unsigned IdxW = PktW - 2;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait
   } state_e;

   // Per-endpoint configuration
   logic [NumInEps-1:0] ep_rdy_q, ep_rdy_d;
   logic [BufIdW-1:0]   ep_buf_q  [NumInEps];
   logic [BufIdW-1:0]   ep_buf_d  [NumInEps];
   logic [PktW:0]       ep_size_q [NumInEps];
   logic [PktW:0]       ep_size_d [NumInEps];
   logic                cfg_err_q, cfg_err_d;
   logic [NumInEps-1:0] ep_sent_q, ep_sent_d;

   // Active transaction snapshot
   logic                busy_q, busy_d;
   logic [3:0]          act_ep_q, act_ep_d;
   logic [BufIdW-1:0]   act_buf_q, act_buf_d;
   logic [PktW:0]       act_size_q, act_size_d;

   // Fetch sequencer
   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic [MemAddrW-1:0] mem_addr_q, mem_addr_d;
   logic [IdxW-1:0]     fetch_idx_q, fetch_idx_d;
   logic                discard_q, discard_d;

   // Held word and byte output
   logic [31:0]         word_q, word_d;
   logic [IdxW-1:0]     word_idx_q, word_idx_d;
   logic                word_vld_q, word_vld_d;
   logic [7:0]          data_q, data_d;

`ifdef USBDEV_IN_PREFETCH_EN
   logic [31:0]         nxt_word_q, nxt_word_d;
   logic [IdxW-1:0]     nxt_idx_q, nxt_idx_d;
   logic                nxt_vld_q, nxt_vld_d;
   logic                fetch_nxt_q, fetch_nxt_d;
   logic [PktW:0]       nxt_byte;
   logic                cur_hit;
`endif

   logic [IdxW-1:0]     get_idx;
   logic                done;
   logic                cfg_ep_ok;
   logic                start_ok;
   logic                cfg_reject;
   logic                resp_outstanding;
   logic [31:0]         sel_word;

   // The engine's consume strobe carries no extra information here: the get
   // address alone selects the byte.
   logic                unused_data_get;
   assign unused_data_get = in_ep_data_get_i;

   assign get_idx   = in_ep_get_addr_i[PktW-1:2];
   assign done      = !busy_q || ({1'b0, in_ep_get_addr_i} >= act_size_q);
   assign cfg_ep_ok = {1'b0, cfg_ep_i} < 5'(NumInEps);
   assign start_ok  = {1'b0, in_xact_start_ep_i} < 5'(NumInEps);

   // A write to the endpoint being served (or being snapshotted this cycle)
   // is refused so the snapshot cannot tear; this also makes xact_end win
   // over a same-cycle write to the active endpoint.
   assign cfg_reject = !cfg_ep_ok
                    || (busy_q && (cfg_ep_i == act_ep_q))
                    || (in_xact_starting_i && (cfg_ep_i == in_xact_start_ep_i));

   // A read response will still arrive after this cycle. New requests are
   // held off until it has been drained, keeping one request outstanding.
   assign resp_outstanding = ((state_q == StWait) && !mem_rvalid_i)
                          || ((state_q == StFetch) && mem_gnt_i)
                          || (discard_q && !mem_rvalid_i);

`ifdef USBDEV_IN_PREFETCH_EN
   assign cur_hit  = word_vld_q && (word_idx_q == get_idx);
   assign nxt_byte = {({1'b0, word_idx_q} + 1'b1), 2'b00};
   // Serve straight from the prefetched word on a boundary crossing.
   assign sel_word = (!cur_hit && nxt_vld_q && (nxt_idx_q == get_idx)) ? nxt_word_q : word_q;
`else
   assign sel_word = word_q;
`endif

   always_comb begin
      ep_rdy_d    = ep_rdy_q;
      ep_buf_d    = ep_buf_q;
      ep_size_d   = ep_size_q;
      cfg_err_d   = 1'b0;
      ep_sent_d   = '0;
      busy_d      = busy_q;
      act_ep_d    = act_ep_q;
      act_buf_d   = act_buf_q;
      act_size_d  = act_size_q;
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      fetch_idx_d = fetch_idx_q;
      discard_d   = discard_q;
      word_d      = word_q;
      word_idx_d  = word_idx_q;
      word_vld_d  = word_vld_q;
`ifdef USBDEV_IN_PREFETCH_EN
      nxt_word_d  = nxt_word_q;
      nxt_idx_d   = nxt_idx_q;
      nxt_vld_d   = nxt_vld_q;
      fetch_nxt_d = fetch_nxt_q;
`endif

      if (discard_q && mem_rvalid_i) begin
         discard_d = 1'b0;
      end

      // Configuration write
      if (cfg_we_i) begin
         if (cfg_reject) begin
            cfg_err_d = 1'b1;
         end else begin
            ep_rdy_d[cfg_ep_i]  = cfg_rdy_i;
            ep_buf_d[cfg_ep_i]  = cfg_buf_i;
            ep_size_d[cfg_ep_i] = cfg_size_i;
         end
      end

      // Fetch sequencer
      unique case (state_q)
         StIdle: begin
            if (busy_q && !done && !discard_q) begin
`ifdef USBDEV_IN_PREFETCH_EN
               if (cur_hit) begin
                  if (!nxt_vld_q && (nxt_byte < act_size_q)) begin
                     state_d     = StFetch;
                     fetch_idx_d = word_idx_q + 1'b1;
                     mem_addr_d  = {act_buf_q, IdxW'(word_idx_q + 1'b1)};
                     fetch_nxt_d = 1'b1;
                  end
               end else if (nxt_vld_q && (nxt_idx_q == get_idx)) begin
                  word_d     = nxt_word_q;
                  word_idx_d = nxt_idx_q;
                  word_vld_d = 1'b1;
                  nxt_vld_d  = 1'b0;
               end else begin
                  state_d     = StFetch;
                  fetch_idx_d = get_idx;
                  mem_addr_d  = {act_buf_q, get_idx};
                  fetch_nxt_d = 1'b0;
               end
`else
               if (!word_vld_q || (word_idx_q != get_idx)) begin
                  state_d     = StFetch;
                  fetch_idx_d = get_idx;
                  mem_addr_d  = {act_buf_q, get_idx};
               end
`endif
            end
         end
         StFetch: begin
            if (mem_gnt_i) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid_i) begin
               state_d = StIdle;
               if (!discard_q && !link_reset_i) begin
`ifdef USBDEV_IN_PREFETCH_EN
                  if (fetch_nxt_q) begin
                     if (busy_q) begin
                        nxt_word_d = mem_rdata_i;
                        nxt_idx_d  = fetch_idx_q;
                        nxt_vld_d  = 1'b1;
                     end
                  end else begin
                     word_d     = mem_rdata_i;
                     word_idx_d = fetch_idx_q;
                     word_vld_d = 1'b1;
                  end
`else
                  word_d     = mem_rdata_i;
                  word_idx_d = fetch_idx_q;
                  word_vld_d = 1'b1;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Termination
      if (busy_q && in_ep_xact_end_i) begin
         ep_rdy_d[act_ep_q]  = 1'b0;
         ep_sent_d[act_ep_q] = 1'b1;
         busy_d              = 1'b0;
      end else if (busy_q && in_ep_rollback_i) begin
         busy_d = 1'b0;
      end
`ifdef USBDEV_IN_PREFETCH_EN
      if (busy_q && (in_ep_xact_end_i || in_ep_rollback_i)) begin
         nxt_vld_d = 1'b0;
      end
`endif

      // Transaction start: overrides any transaction in flight. A response
      // still due for the old transaction is drained via the discard flag
      // before word 0 is requested from Idle.
      if (in_xact_starting_i && start_ok) begin
         busy_d     = 1'b1;
         act_ep_d   = in_xact_start_ep_i;
         act_buf_d  = ep_buf_q[in_xact_start_ep_i];
         act_size_d = ep_size_q[in_xact_start_ep_i];
         word_vld_d = 1'b0;
`ifdef USBDEV_IN_PREFETCH_EN
         nxt_vld_d   = 1'b0;
         fetch_nxt_d = 1'b0;
`endif
         if (resp_outstanding) begin
            state_d   = StIdle;
            discard_d = 1'b1;
         end else if (ep_size_q[in_xact_start_ep_i] != '0) begin
            state_d     = StFetch;
            fetch_idx_d = '0;
            mem_addr_d  = {ep_buf_q[in_xact_start_ep_i], {IdxW{1'b0}}};
         end else begin
            state_d = StIdle;
         end
      end

      // Bus reset overrides everything else
      if (link_reset_i) begin
         ep_rdy_d   = '0;
         ep_sent_d  = '0;
         busy_d     = 1'b0;
         word_vld_d = 1'b0;
         state_d    = StIdle;
         discard_d  = discard_d | resp_outstanding;
`ifdef USBDEV_IN_PREFETCH_EN
         nxt_vld_d   = 1'b0;
         fetch_nxt_d = 1'b0;
`endif
      end
   end

   assign mem_req_d = (state_d == StFetch);
   assign data_d    = sel_word[{in_ep_get_addr_i[1:0], 3'b000} +: 8];

   always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ep_rdy_q    <= '0;
         ep_buf_q    <= '{default: '0};
         ep_size_q   <= '{default: '0};
         cfg_err_q   <= 1'b0;
         ep_sent_q   <= '0;
         busy_q      <= 1'b0;
         act_ep_q    <= '0;
         act_buf_q   <= '0;
         act_size_q  <= '0;
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         fetch_idx_q <= '0;
         discard_q   <= 1'b0;
         word_q      <= '0;
         word_idx_q  <= '0;
         word_vld_q  <= 1'b0;
         data_q      <= '0;
`ifdef USBDEV_IN_PREFETCH_EN
         nxt_word_q  <= '0;
         nxt_idx_q   <= '0;
         nxt_vld_q   <= 1'b0;
         fetch_nxt_q <= 1'b0;
`endif
      end else begin
         ep_rdy_q    <= ep_rdy_d;
         ep_buf_q    <= ep_buf_d;
         ep_size_q   <= ep_size_d;
         cfg_err_q   <= cfg_err_d;
         ep_sent_q   <= ep_sent_d;
         busy_q      <= busy_d;
         act_ep_q    <= act_ep_d;
         act_buf_q   <= act_buf_d;
         act_size_q  <= act_size_d;
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         fetch_idx_q <= fetch_idx_d;
         discard_q   <= discard_d;
         word_q      <= word_d;
         word_idx_q  <= word_idx_d;
         word_vld_q  <= word_vld_d;
         data_q      <= data_d;
`ifdef USBDEV_IN_PREFETCH_EN
         nxt_word_q  <= nxt_word_d;
         nxt_idx_q   <= nxt_idx_d;
         nxt_vld_q   <= nxt_vld_d;
         fetch_nxt_q <= fetch_nxt_d;
`endif
      end
   end

   assign cfg_err_o         = cfg_err_q;
   assign ep_rdy_o          = ep_rdy_q;
   assign ep_sent_o         = ep_sent_q;
   assign in_ep_has_data_o  = ep_rdy_q;
   assign in_ep_data_done_o = {NumInEps{done}};
   assign in_ep_data_o      = data_q;
   assign mem_req_o         = mem_req_q;
   assign mem_addr_o        = mem_addr_q;

endmodule

// File: tb/tb_usbdev_in_buf_ctrl.sv
// ----------------------------------------------------------------------------
// Directed testbench for usbdev_in_buf_ctrl: configuration, fetch/serve,
// word crossing, termination, rollback, rejected writes, bus reset mid-fetch
// and zero-length packets. Expected SRAM addresses and bytes are queued when
// stimulus is driven and compared when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_usbdev_in_buf_ctrl;

   localparam int unsigned NumInEps = 12;
   localparam int unsigned PktW     = 6;
   localparam int unsigned BufIdW   = 5;
   localparam int unsigned MemAddrW = 9;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                link_reset;
   logic                cfg_we;
   logic [3:0]          cfg_ep;
   logic [BufIdW-1:0]   cfg_buf;
   logic [PktW:0]       cfg_size;
   logic                cfg_rdy;
   logic                cfg_err;
   logic [NumInEps-1:0] ep_rdy, ep_sent, has_data, data_done;
   logic                xact_starting;
   logic [3:0]          start_ep;
   logic [PktW-1:0]     get_addr;
   logic                data_get, xact_end, rollback;
   logic [7:0]          data;
   logic                mem_req;
   logic [MemAddrW-1:0] mem_addr;
   logic                mem_gnt, mem_rvalid;
   logic [31:0]         mem_rdata;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   usbdev_in_buf_ctrl #(
      .NumInEps         (12),
      .MaxInPktSizeByte (64),
      .BufIdW           (5)
   ) dut (
      .clk_48mhz_i        (clk),
      .rst_ni             (rst_n),
      .link_reset_i       (link_reset),
      .cfg_we_i           (cfg_we),
      .cfg_ep_i           (cfg_ep),
      .cfg_buf_i          (cfg_buf),
      .cfg_size_i         (cfg_size),
      .cfg_rdy_i          (cfg_rdy),
      .cfg_err_o          (cfg_err),
      .ep_rdy_o           (ep_rdy),
      .ep_sent_o          (ep_sent),
      .in_xact_starting_i (xact_starting),
      .in_xact_start_ep_i (start_ep),
      .in_ep_get_addr_i   (get_addr),
      .in_ep_data_get_i   (data_get),
      .in_ep_xact_end_i   (xact_end),
      .in_ep_rollback_i   (rollback),
      .in_ep_has_data_o   (has_data),
      .in_ep_data_done_o  (data_done),
      .in_ep_data_o       (data),
      .mem_req_o          (mem_req),
      .mem_addr_o         (mem_addr),
      .mem_gnt_i          (mem_gnt),
      .mem_rvalid_i       (mem_rvalid),
      .mem_rdata_i        (mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL sb_underflow: observed 0x%0h expected a queued value", obs);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic cfg_write(input logic [3:0] ep, input logic [BufIdW-1:0] b,
                            input logic [PktW:0] sz, input logic rdy);
      cfg_we   = 1'b1;
      cfg_ep   = ep;
      cfg_buf  = b;
      cfg_size = sz;
      cfg_rdy  = rdy;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic start(input logic [3:0] ep);
      xact_starting = 1'b1;
      start_ep      = ep;
      tick();
      xact_starting = 1'b0;
   endtask

   // Waits (bounded) for a request, checks its address against the queue,
   // grants it and returns rdata one cycle later.
   task automatic serve_fetch(input logic [31:0] rdata);
      for (int i = 0; i < 10 && !mem_req; i++) tick();
      tests++;
      assert (mem_req === 1'b1) else begin
         fails++;
         $error("FAIL req_timeout: observed mem_req_o 0x%0h expected 0x1", mem_req);
      end
      sb_check(32'(mem_addr));
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      tick();
   endtask

   task automatic get_byte(input logic [PktW-1:0] a, input logic [7:0] exp);
      get_addr = a;
      sb_push($sformatf("byte_at_%0d", a), 32'(exp));
      tick();
      sb_check(32'(data));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; link_reset = 1'b0;
      cfg_we = 1'b0; cfg_ep = '0; cfg_buf = '0; cfg_size = '0; cfg_rdy = 1'b0;
      xact_starting = 1'b0; start_ep = '0; get_addr = '0; data_get = 1'b0;
      xact_end = 1'b0; rollback = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // Reset state
      tick(); tick();
      check("rst_ep_rdy",   32'(ep_rdy),   32'h0);
      check("rst_has_data", 32'(has_data), 32'h0);
      check("rst_ep_sent",  32'(ep_sent),  32'h0);
      check("rst_cfg_err",  32'(cfg_err),  32'h0);
      check("rst_mem_req",  32'(mem_req),  32'h0);
      check("rst_data",     32'(data),     32'h0);
      rst_n = 1'b1;
      tick();

      // Config ep2 buf3 size5, then fetch word 0
      cfg_write(4'd2, 5'd3, 7'd5, 1'b1);
      check("cfg_ep_rdy",   32'(ep_rdy),   32'h004);
      check("cfg_has_data", 32'(has_data), 32'h004);
      check("cfg_no_err",   32'(cfg_err),  32'h0);
      get_addr = '0;
      sb_push("fetch_w0", 32'h030);
      start(4'd2);
      check("busy_not_done", 32'(data_done), 32'h000);
      serve_fetch(32'h4433_2211);
      get_byte(6'd0, 8'h11);
      get_byte(6'd1, 8'h22);
      get_byte(6'd2, 8'h33);
      get_byte(6'd3, 8'h44);

      // Word crossing, done at size, good termination
      get_addr = 6'd4;
      sb_push("fetch_w1", 32'h031);
      serve_fetch(32'hDDCC_BBAA);
      get_byte(6'd4, 8'hAA);
      check("done_at_4", 32'(data_done), 32'h000);
      get_addr = 6'd5;
      #1;
      check("done_at_5", 32'(data_done), 32'hFFF);
      xact_end = 1'b1;
      tick();
      xact_end = 1'b0;
      check("sent_pulse", 32'(ep_sent), 32'h004);
      check("rdy_cleared", 32'(ep_rdy), 32'h000);
      tick();
      check("sent_once", 32'(ep_sent), 32'h000);
      check("idle_done", 32'(data_done), 32'hFFF);

      // Rollback keeps the packet pending; restart refetches word 0
      cfg_write(4'd2, 5'd3, 7'd5, 1'b1);
      get_addr = '0;
      sb_push("fetch_rb", 32'h030);
      start(4'd2);
      serve_fetch(32'h4433_2211);
      get_byte(6'd1, 8'h22);
      get_byte(6'd2, 8'h33);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("rb_rdy_kept", 32'(ep_rdy), 32'h004);
      check("rb_no_sent",  32'(ep_sent), 32'h000);
      tick();
      check("rb_no_sent2", 32'(ep_sent), 32'h000);
      get_addr = '0;
      sb_push("fetch_restart", 32'h030);
      start(4'd2);
      serve_fetch(32'h4433_2211);
      get_byte(6'd0, 8'h11);

      // Rejected writes while ep2 is busy; other endpoints still accepted
      cfg_write(4'd2, 5'd7, 7'd9, 1'b0);
      check("busy_err", 32'(cfg_err), 32'h1);
      check("busy_rdy_kept", 32'(ep_rdy), 32'h004);
      tick();
      check("busy_err_pulse", 32'(cfg_err), 32'h0);
      cfg_write(4'd12, 5'd1, 7'd4, 1'b1);
      check("ep12_err", 32'(cfg_err), 32'h1);
      check("ep12_rdy", 32'(ep_rdy), 32'h004);
      cfg_write(4'd5, 5'd9, 7'd8, 1'b1);
      check("ep5_ok", 32'(cfg_err), 32'h0);
      check("ep5_rdy", 32'(ep_rdy), 32'h024);
      xact_end = 1'b1;
      tick();
      xact_end = 1'b0;
      check("end2_sent", 32'(ep_sent), 32'h004);
      // ep2 buffer/size must still be 3/5
      get_addr = '0;
      sb_push("fetch_unchanged", 32'h030);
      start(4'd2);
      serve_fetch(32'h4433_2211);
      get_addr = 6'd5;
      #1;
      check("size_unchanged", 32'(data_done), 32'hFFF);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;

      // Bus reset while a request waits for grant
      cfg_write(4'd2, 5'd3, 7'd5, 1'b1);
      get_addr = '0;
      start(4'd2);
      tick();
      check("lr_req_held", 32'(mem_req), 32'h1);
      check("lr_addr", 32'(mem_addr), 32'h030);
      link_reset = 1'b1;
      tick();
      link_reset = 1'b0;
      check("lr_req_drop", 32'(mem_req), 32'h0);
      check("lr_rdy_clr", 32'(ep_rdy), 32'h000);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      tick();
      check("lr_stray_data", 32'(data), 32'h11);
      check("lr_no_req", 32'(mem_req), 32'h0);

      // Zero-length packet
      cfg_write(4'd4, 5'd1, 7'd0, 1'b1);
      check("zl_has_data", 32'(has_data), 32'h010);
      start(4'd4);
      check("zl_done", 32'(data_done), 32'hFFF);
      tick(); tick(); tick();
      check("zl_no_req", 32'(mem_req), 32'h0);
      xact_end = 1'b1;
      tick();
      xact_end = 1'b0;
      check("zl_sent", 32'(ep_sent), 32'h010);
      check("zl_rdy_clr", 32'(ep_rdy), 32'h000);

      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usbdev_in_buf_ctrl.md
Name: usbdev_in_buf_ctrl

Overview:
- Sequences the packet-buffer datapath behind the full-speed non-buffered IN protocol engine.
- Holds per-endpoint software configuration: ready flag, buffer id and packet size.
- Snapshots that configuration at IN transaction start, fetches 32-bit words from packet SRAM, and serves bytes by the engine's get address.
- Retires packets on good termination and leaves them pending on rollback.

Parameters:
- NumInEps, 12, number of implemented IN endpoints.
- MaxInPktSizeByte, 64, maximum packet size; derived PktW = $clog2(MaxInPktSizeByte).
- BufIdW, 5, buffer id width; SRAM word address = {buf_id, byte_addr[PktW-1:2]}.
- MemAddrW, BufIdW + PktW - 2 (derived), SRAM word address width.

Ports:
- clk_48mhz_i in 1: clock.
- rst_ni in 1: reset, async active-low.
- link_reset_i in 1: bus reset.
- cfg_we_i in 1: config write strobe.
- cfg_ep_i in 4: endpoint selected by the config write.
- cfg_buf_i in BufIdW: buffer id.
- cfg_size_i in PktW+1: packet size, 0..MaxInPktSizeByte.
- cfg_rdy_i in 1: ready value.
- cfg_err_o out 1: pulse when a config write is rejected.
- ep_rdy_o out NumInEps: per-endpoint ready.
- ep_sent_o out NumInEps: one-cycle pulse when a packet is sent.
- in_xact_starting_i in 1: IN transaction is starting.
- in_xact_start_ep_i in 4: endpoint of the starting transaction.
- in_ep_get_addr_i in PktW: byte offset requested by the engine.
- in_ep_data_get_i in 1: engine consumed a byte.
- in_ep_xact_end_i in 1: good transaction termination.
- in_ep_rollback_i in 1: bad termination, rollback.
- in_ep_has_data_o out NumInEps: equals ep_rdy_o.
- in_ep_data_done_o out NumInEps: all bits carry the done flag of the active endpoint.
- in_ep_data_o out 8: byte for in_ep_get_addr_i.
- mem_req_o out 1: SRAM read request.
- mem_addr_o out MemAddrW: SRAM word address.
- mem_gnt_i in 1: SRAM grant.
- mem_rvalid_i in 1: SRAM read data valid.
- mem_rdata_i in 32: SRAM read data.

Behaviour:
Reset values:
- All outputs 0, all config registers 0, FSM in Idle, held word invalid.
- Reset is asynchronous and may occur mid-fetch.

Configuration writes:
- A write with cfg_ep_i >= NumInEps is ignored and pulses cfg_err_o on the next cycle.
- A write to the active endpoint while busy is ignored and pulses cfg_err_o on the next cycle. Busy means from in_xact_starting_i until xact_end or rollback.
- Otherwise the new values take effect on the next cycle.

Transaction start:
- On in_xact_starting_i, latch act_ep, act_buf and act_size, set busy, and invalidate the held word.
- The FSM goes to Fetch for word 0.
- If the transaction is restarted while busy, the new start overrides. Any outstanding rvalid is discarded via a pending-response flag.

FSM states:
- Idle: no request is issued.
  - Go to Fetch when busy and either the held word is invalid or the held word index differs from get_addr[PktW-1:2].
- Fetch: mem_req_o=1 and mem_addr_o stable until mem_gnt_i. On gnt go to Wait.
- Wait: on mem_rvalid_i, capture mem_rdata_i and set the word index and valid flag; go to Idle.
  - rvalid data is dropped when a discard is pending or when link_reset_i is asserted.
- At most one request is outstanding at any time.

Data path:
- in_ep_data_o = held_word[8*get_addr[1:0] +: 8], registered. Latency is 1 cycle after the word is valid; byte 0 is little-endian.
- data_done is combinational: (get_addr >= act_size) or not busy.
- act_size == 0 gives data_done=1 immediately and no fetch is issued.

Termination:
- in_ep_xact_end_i: clear ep_rdy[act_ep], pulse ep_sent_o[act_ep] on the next cycle, clear busy.
- in_ep_rollback_i: clear busy, keep ep_rdy. The next start refetches from byte 0.
- If xact_end and a cfg write to the same endpoint occur in the same cycle, xact_end wins and the write is rejected.

Link reset:
- link_reset_i clears all ep_rdy and busy and sends the FSM to Idle.
- A request in Fetch is dropped immediately; a Wait response is discarded when it arrives.
- The held word is invalidated.

Optional Feature:
USBDEV_IN_PREFETCH_EN
- Defined:
  - Adds a second word register.
  - After the current word is valid, and while (index+1)*4 < act_size, the next word is fetched ahead of time.
  - When get_addr crosses a word boundary the prefetched word swaps in, so there is zero refetch latency.
  - A stale prefetch is dropped on start, rollback or link reset.
- Undefined:
  - Single word register with on-demand fetch only.
  - A word-boundary crossing stalls for 2+ cycles, which is acceptable at 32 clocks per byte.

Test Plan:
- Config: cfg ep2, buf 3, size 5, rdy 1; start ep2 -> mem_addr_o={3,0}. With rdata 0x44332211, get_addr 0..3 gives bytes 11,22,33,44.
- Word crossing: get_addr 4 -> refetch {3,1}. Then get_addr 5 -> data_done=1; xact_end -> ep_sent_o[2] pulses once and ep_rdy_o[2]=0.
- Rollback: same setup, rollback after byte 2 -> ep_rdy_o[2] stays 1, no sent pulse. Restart -> fetch {3,0} again.
- Busy rejection: cfg_we to ep2 during its transaction -> cfg_err_o pulse, config unchanged. cfg_we to ep12 -> cfg_err_o pulse.
- Reset mid-fetch: hold mem_gnt_i=0, assert link_reset_i -> mem_req_o drops next cycle, all ep_rdy 0. A later stray rvalid -> data ignored.
- Zero-length: size 0, rdy 1 -> has_data=1, data_done=1, no mem_req_o; xact_end -> sent pulse.
